mmio_periph_tiny: RTL and testbench
===================================

Name: mmio_periph_tiny

Overview:
- MMIO slave on the tiny-SoC MMIO bus (req/we/addr/strb/wdata in, rdata out); consumes the requests the core emits toward the MMIO window.
- Provides a CLINT-style machine timer (mtime/mtimecmp, timer interrupt), a byte console TX FIFO drained by a valid/ready sink, and a sticky exit/halt register for simulation termination.
- Sits directly downstream of the SoC top's MMIO port.

Parameters:
- MMIOAddrWidth, 31, MMIO address width.
- DataWidth, 64, bus data width (fixed 64; StrbWidth = 8).
- BaseAddr, 31'h1000_0000, window base; decode on addr[MMIOAddrWidth-1:8] == BaseAddr[MMIOAddrWidth-1:8].
- TxFifoDepth, 16, TX FIFO entries; power of two, at least 2.
- TickDiv, 1, clk cycles per mtime increment; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-high.
- mmio_req_i  in  1  request valid for one cycle; no backpressure.
- mmio_we_i  in  1  1 = write, 0 = read.
- mmio_addr_i  in  MMIOAddrWidth  byte address; bits [2:0] ignored.
- mmio_strb_i  in  8  write byte strobes.
- mmio_wdata_i  in  64  write data.
- mmio_rdata_o  out  64  read data, registered.
- timer_irq_o  out  1  registered (mtime >= mtimecmp).
- tx_valid_o  out  1  FIFO non-empty.
- tx_data_o  out  8  FIFO head byte.
- tx_ready_i  in  1  sink accepts the head when valid && ready.
- halt_o  out  1  sticky halt.
- exit_code_o  out  32  value captured at halt.

Behaviour:
- Reset values: mmio_rdata_o=0, timer_irq_o=0, tx_valid_o=0, tx_data_o=0, halt_o=0, exit_code_o=0, mtime=0, mtimecmp=all-ones, prescaler=0, FIFO empty, overflow=0.
- Register map (offset from BaseAddr):
  - 0x00 MTIME, RW.
  - 0x08 MTIMECMP, RW.
  - 0x10 TXDATA, W. A write with strb[0] pushes wdata[7:0]. Reads return 0.
  - 0x18 STATUS, RO. bit0 full, bit1 empty, bit2 overflow (sticky; a write with strb[0] and wdata[2]=1 clears it), bits[15:8] count.
  - 0x20 EXIT, W. A write with strb[0] sets halt_o=1 and exit_code_o=wdata[31:0]. Later writes are ignored.
- Unmapped offsets and out-of-window addresses: reads return 0; writes have no effect; no error signal.
- Read latency is exactly 1 cycle. mmio_rdata_o is updated only in the cycle after a read request and holds its value otherwise. A read samples register state before any same-cycle update.
- MTIME/MTIMECMP writes are byte-masked by strb.
- mtime increments by 1 when the prescaler reaches TickDiv-1; the prescaler then wraps to 0. A same-cycle software write to MTIME wins over the increment, and the write also resets the prescaler. mtime wraps modulo 2^64.
- timer_irq_o is registered, one cycle behind the compare, and recomputed every cycle (level, not sticky).
- FIFO:
  - push = TXDATA write with strb[0].
  - pop = tx_valid_o && tx_ready_i.
  - A push is accepted when count < TxFifoDepth or a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop leave count unchanged.
  - tx_data_o is the head entry; it is 0 when empty.
  - tx_data_o/tx_valid_o are stable while valid && !ready.
- After halt, the timer keeps running and the FIFO keeps draining.
- Reset asserted mid-operation clears all state immediately; a request in flight is lost.

Decomposition:
- Shared package tiny_soc_mmio_pkg:
  - offset constants MMIO_MTIME_OFF, MMIO_MTIMECMP_OFF, MMIO_TXDATA_OFF, MMIO_STATUS_OFF, MMIO_EXIT_OFF;
  - STATUS bit-index constants;
  - mmio_addr_t, data_t, strb_t typedefs.
- One sub-module mmio_tx_fifo (parameter Depth). It has push/data/full/pop/valid/head/count ports, a circular buffer with pointer wrap, and an extra wrap bit for full/empty.

Test Plan:
- Reset, then read 0x08 → next-cycle rdata=64'hFFFF_FFFF_FFFF_FFFF; read 0x00 after 10 cycles (TickDiv=1) → value in 9..11 range, exact per bench reference model.
- Write MTIMECMP=20 with mtime=0 → timer_irq_o rises exactly one cycle after mtime reaches 20. Then write MTIMECMP=all-ones → irq falls one cycle later.
- Write MTIME with strb=8'h0F, wdata=64'h1111_2222_3333_4444 over mtime=0 → mtime low word = 32'h3333_4444 (the upper word is not written), and the same-cycle increment is suppressed.
- Hold tx_ready_i=0 and push 17 bytes 0x41..0x51 → STATUS reads full=1, count=16, overflow=1. With tx_ready_i=1, 0x41..0x50 drain in order and 0x51 never appears.
- With the FIFO full, push 0x5A in the same cycle as a pop → count stays 16, overflow unchanged, and 0x5A is the last byte out.
- Write EXIT with wdata=32'hDEAD_0001, then EXIT 32'h2 → halt_o=1, exit_code_o=32'hDEAD_0001. Then assert rst_i asynchronously mid-cycle → all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/tiny_soc_mmio_pkg.sv
// Shared definitions for the tiny-SoC MMIO peripheral: register offsets,
// STATUS bit positions, bus typedefs and the byte-strobe merge helper.
package tiny_soc_mmio_pkg;

  typedef logic [30:0] mmio_addr_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

  localparam logic [7:0] MMIO_MTIME_OFF    = 8'h00;
  localparam logic [7:0] MMIO_MTIMECMP_OFF = 8'h08;
  localparam logic [7:0] MMIO_TXDATA_OFF   = 8'h10;
  localparam logic [7:0] MMIO_STATUS_OFF   = 8'h18;
  localparam logic [7:0] MMIO_EXIT_OFF     = 8'h20;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;
  localparam int STATUS_COUNT_LSB = 8;

  // Byte lanes with a set strobe take the new value; the rest keep the old one.
  function automatic data_t apply_strb(input data_t old_val, input data_t new_val,
                                       input strb_t strb);
    data_t res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO for the console TX path: circular buffer whose pointers carry an
// extra wrap bit so that full and empty are distinguishable.
module mmio_tx_fifo #(
  parameter int Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [7:0]               head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [Depth];
  logic        empty;
  logic        pop_ok;
  logic        push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign valid_o = !empty;
  assign head_o  = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mmio_periph_tiny.sv
// MMIO slave for the tiny SoC: machine timer with compare interrupt, console
// TX byte FIFO and a sticky exit/halt register for ending simulations.
module mmio_periph_tiny
  import tiny_soc_mmio_pkg::*;
#(
  parameter int                       MMIOAddrWidth = 31,
  parameter int                       DataWidth     = 64,
  parameter logic [MMIOAddrWidth-1:0] BaseAddr      = 31'h1000_0000,
  parameter int                       TxFifoDepth   = 16,
  parameter int                       TickDiv       = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mmio_req_i,
  input  logic                     mmio_we_i,
  input  logic [MMIOAddrWidth-1:0] mmio_addr_i,
  input  logic [7:0]               mmio_strb_i,
  input  logic [DataWidth-1:0]     mmio_wdata_i,
  output logic [DataWidth-1:0]     mmio_rdata_o,
  output logic                     timer_irq_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i,
  output logic                     halt_o,
  output logic [31:0]              exit_code_o
);

  localparam int PW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int CW = $clog2(TxFifoDepth) + 1;

  data_t         rdata_q, rdata_d;
  data_t         mtime_q, mtime_d;
  data_t         mtimecmp_q, mtimecmp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic          halt_q, halt_d;
  logic [31:0]   exit_q, exit_d;

  logic          in_window;
  logic [7:0]    offset;
  logic          wr_en;
  logic          wr_mtime, wr_cmp, wr_tx, wr_status, wr_exit;
  logic          tick;
  logic          fifo_push, fifo_pop, fifo_full;
  logic [CW-1:0] fifo_count;
  data_t         status_word;
  data_t         read_val;
  logic          unused_addr_lsbs;

  assign in_window = (mmio_addr_i[MMIOAddrWidth-1:8] == BaseAddr[MMIOAddrWidth-1:8]);
  assign offset    = {mmio_addr_i[7:3], 3'b000};
  assign wr_en     = mmio_req_i && mmio_we_i && in_window;
  assign wr_mtime  = wr_en && (offset == MMIO_MTIME_OFF);
  assign wr_cmp    = wr_en && (offset == MMIO_MTIMECMP_OFF);
  assign wr_tx     = wr_en && (offset == MMIO_TXDATA_OFF);
  assign wr_status = wr_en && (offset == MMIO_STATUS_OFF);
  assign wr_exit   = wr_en && (offset == MMIO_EXIT_OFF);
  assign unused_addr_lsbs = ^mmio_addr_i[2:0];

  assign fifo_push = wr_tx && mmio_strb_i[0];
  assign fifo_pop  = tx_valid_o && tx_ready_i;

  mmio_tx_fifo #(
    .Depth (TxFifoDepth)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (mmio_wdata_i[7:0]),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .valid_o (tx_valid_o),
    .head_o  (tx_data_o),
    .count_o (fifo_count)
  );

  always_comb begin
    status_word                     = '0;
    status_word[STATUS_FULL_BIT]    = fifo_full;
    status_word[STATUS_EMPTY_BIT]   = !tx_valid_o;
    status_word[STATUS_OVF_BIT]     = ovf_q;
    status_word[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
  end

  // Reads see the pre-update register state; rdata holds between reads.
  always_comb begin
    read_val = '0;
    if (in_window) begin
      case (offset)
        MMIO_MTIME_OFF:    read_val = mtime_q;
        MMIO_MTIMECMP_OFF: read_val = mtimecmp_q;
        MMIO_STATUS_OFF:   read_val = status_word;
        default:           read_val = '0;
      endcase
    end
    rdata_d = (mmio_req_i && !mmio_we_i) ? read_val : rdata_q;
  end

  // Software writes to MTIME take priority over the tick and restart the prescaler.
  always_comb begin
    tick       = (presc_q == PW'(TickDiv - 1));
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    if (wr_mtime) begin
      mtime_d = apply_strb(mtime_q, mmio_wdata_i, mmio_strb_i);
      presc_d = '0;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    mtimecmp_d = wr_cmp ? apply_strb(mtimecmp_q, mmio_wdata_i, mmio_strb_i) : mtimecmp_q;
    irq_d      = (mtime_q >= mtimecmp_q);
  end

  always_comb begin
    ovf_d  = ovf_q;
    halt_d = halt_q;
    exit_d = exit_q;
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_status && mmio_strb_i[0] && mmio_wdata_i[STATUS_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
    if (wr_exit && mmio_strb_i[0] && !halt_q) begin
      halt_d = 1'b1;
      exit_d = mmio_wdata_i[31:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      halt_q     <= 1'b0;
      exit_q     <= '0;
    end else begin
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      exit_q     <= exit_d;
    end
  end

  assign mmio_rdata_o = rdata_q;
  assign timer_irq_o  = irq_q;
  assign halt_o       = halt_q;
  assign exit_code_o  = exit_q;

endmodule

// File: tb/tb_mmio_periph_tiny.sv
// Directed plus randomized bench for mmio_periph_tiny, checked every cycle
// against a cycle-level reference model built on plain counters and a queue.
module tb_mmio_periph_tiny;

  localparam logic [30:0] BASE    = 31'h1000_0000;
  localparam int          DEPTH   = 16;
  localparam int          TICKDIV = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_req = 1'b0;
  logic        mmio_we = 1'b0;
  logic [30:0] mmio_addr = BASE;
  logic [7:0]  mmio_strb = 8'h00;
  logic [63:0] mmio_wdata = 64'h0;
  logic        tx_ready = 1'b0;
  logic [63:0] mmio_rdata_o;
  logic        timer_irq_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        halt_o;
  logic [31:0] exit_code_o;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_mtime, m_cmp, m_rdata;
  int          m_presc;
  bit          m_irq, m_ovf, m_halt;
  logic [31:0] m_exit;
  logic [7:0]  m_q[$];
  logic [7:0]  drained[$];

  always #5 clk = ~clk;

  mmio_periph_tiny #(
    .MMIOAddrWidth (31),
    .DataWidth     (64),
    .BaseAddr      (BASE),
    .TxFifoDepth   (DEPTH),
    .TickDiv       (TICKDIV)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mmio_req_i   (mmio_req),
    .mmio_we_i    (mmio_we),
    .mmio_addr_i  (mmio_addr),
    .mmio_strb_i  (mmio_strb),
    .mmio_wdata_i (mmio_wdata),
    .mmio_rdata_o (mmio_rdata_o),
    .timer_irq_o  (timer_irq_o),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready),
    .halt_o       (halt_o),
    .exit_code_o  (exit_code_o)
  );

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic void modelReset();
    m_mtime = 64'd0;
    m_cmp   = '1;
    m_rdata = 64'd0;
    m_presc = 0;
    m_irq   = 1'b0;
    m_ovf   = 1'b0;
    m_halt  = 1'b0;
    m_exit  = 32'd0;
    m_q.delete();
  endfunction

  function automatic logic [63:0] statusValue();
    int n;
    n = m_q.size();
    return (64'(n) << 8) | (64'(m_ovf) << 2) | (64'(n == 0) << 1) | 64'(n == DEPTH);
  endfunction

  // One clock of the reference model, evaluated from the inputs driven this cycle.
  function automatic void modelStep();
    bit          hit, wr, pop, push;
    int          off;
    logic [63:0] nt, nc;
    hit = (mmio_addr >> 8) == (BASE >> 8);
    off = int'(mmio_addr[7:0]) & 'hF8;
    wr  = mmio_req && mmio_we && hit;
    if (mmio_req && !mmio_we) begin
      if (!hit)            m_rdata = 64'd0;
      else if (off == 0)   m_rdata = m_mtime;
      else if (off == 8)   m_rdata = m_cmp;
      else if (off == 'h18) m_rdata = statusValue();
      else                 m_rdata = 64'd0;
    end
    nt = m_mtime;
    nc = m_cmp;
    if (wr && off == 0) begin
      nt = merge(m_mtime, mmio_wdata, mmio_strb);
      m_presc = 0;
    end else if (m_presc + 1 >= TICKDIV) begin
      nt = m_mtime + 64'd1;
      m_presc = 0;
    end else begin
      m_presc = m_presc + 1;
    end
    if (wr && off == 8) nc = merge(m_cmp, mmio_wdata, mmio_strb);
    if (wr && off == 'h18 && mmio_strb[0] && mmio_wdata[2]) m_ovf = 1'b0;
    if (wr && off == 'h20 && mmio_strb[0] && !m_halt) begin
      m_halt = 1'b1;
      m_exit = mmio_wdata[31:0];
    end
    pop  = (m_q.size() > 0) && tx_ready;
    push = wr && off == 'h10 && mmio_strb[0];
    m_irq = (m_mtime >= m_cmp);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(mmio_wdata[7:0]);
      else m_ovf = 1'b1;
    end
    m_mtime = nt;
    m_cmp   = nc;
  endfunction

  task automatic checkOutput();
    check64("rdata", mmio_rdata_o, m_rdata);
    check64("timer_irq", 64'(timer_irq_o), 64'(m_irq));
    check64("tx_valid", 64'(tx_valid_o), 64'(m_q.size() > 0));
    check64("tx_data", 64'(tx_data_o), (m_q.size() > 0) ? 64'(m_q[0]) : 64'd0);
    check64("halt", 64'(halt_o), 64'(m_halt));
    check64("exit_code", 64'(exit_code_o), 64'(m_exit));
  endtask

  task automatic applyStimulus(input bit req, input bit we, input logic [30:0] addr,
                               input logic [7:0] strb, input logic [63:0] wdata);
    mmio_req   = req;
    mmio_we    = we;
    mmio_addr  = addr;
    mmio_strb  = strb;
    mmio_wdata = wdata;
    if (tx_valid_o && tx_ready) drained.push_back(tx_data_o);
    modelStep();
    @(posedge clk);
    #1;
    mmio_req = 1'b0;
    checkOutput();
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [7:0] strb, input logic [63:0] d);
    applyStimulus(1'b1, 1'b1, BASE + 31'(off), strb, d);
  endtask

  task automatic readReg(input logic [7:0] off);
    applyStimulus(1'b1, 1'b0, BASE + 31'(off), 8'h00, 64'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, BASE, 8'h00, 64'd0);
  endtask

  initial begin
    logic [7:0]  offs [8];
    logic [7:0]  off;
    logic [30:0] addr;
    logic [7:0]  strb;
    logic [63:0] wd;

    offs[0] = 8'h00; offs[1] = 8'h08; offs[2] = 8'h10; offs[3] = 8'h10;
    offs[4] = 8'h18; offs[5] = 8'h20; offs[6] = 8'h28; offs[7] = 8'hF0;

    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
    $display("[TB] reset released");

    readReg(8'h08);
    check64("cmp_reset_read", mmio_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(9);
    readReg(8'h00);
    check64("mtime_range", 64'((mmio_rdata_o >= 64'd9) && (mmio_rdata_o <= 64'd11)), 64'd1);

    writeReg(8'h00, 8'hFF, 64'd0);
    writeReg(8'h08, 8'hFF, 64'd20);
    idle(25);
    check64("irq_high", 64'(timer_irq_o), 64'd1);
    writeReg(8'h08, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(2);
    check64("irq_low", 64'(timer_irq_o), 64'd0);

    writeReg(8'h00, 8'hFF, 64'd0);
    writeReg(8'h00, 8'h0F, 64'h1111_2222_3333_4444);
    readReg(8'h00);
    check64("mtime_masked", mmio_rdata_o, 64'h0000_0000_3333_4444);

    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) writeReg(8'h10, 8'h01, 64'(8'h41 + i));
    readReg(8'h18);
    check64("status_full", mmio_rdata_o, 64'h0000_0000_0000_1005);
    drained.delete();
    tx_ready = 1'b1;
    writeReg(8'h10, 8'h01, 64'h5A);
    tx_ready = 1'b0;
    readReg(8'h18);
    check64("status_push_pop", mmio_rdata_o, 64'h0000_0000_0000_1005);
    writeReg(8'h18, 8'h01, 64'h4);
    readReg(8'h18);
    check64("status_ovf_clr", mmio_rdata_o, 64'h0000_0000_0000_1001);
    tx_ready = 1'b1;
    idle(20);
    check64("drain_len", 64'(drained.size()), 64'd17);
    for (int i = 0; i < 16 && i < drained.size(); i++)
      check64("drain_byte", 64'(drained[i]), 64'(8'h41 + i));
    if (drained.size() == 17) check64("drain_last", 64'(drained[16]), 64'h5A);
    readReg(8'h18);
    check64("status_empty", mmio_rdata_o, 64'h0000_0000_0000_0002);

    writeReg(8'h20, 8'hFF, 64'h0000_0000_DEAD_0001);
    writeReg(8'h20, 8'hFF, 64'h0000_0000_0000_0002);
    check64("halt_set", 64'(halt_o), 64'd1);
    check64("exit_first", 64'(exit_code_o), 64'h0000_0000_DEAD_0001);

    $display("[TB] random phase");
    for (int it = 0; it < 400; it++) begin
      tx_ready = 1'($urandom_range(0, 1));
      off  = offs[$urandom_range(0, 7)];
      addr = BASE + 31'(off) + 31'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr = addr ^ (31'd1 << $urandom_range(8, 30));
      strb = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      wd   = {$urandom, $urandom};
      if (off == 8'h00 || off == 8'h08) wd = 64'($urandom_range(0, 800));
      case ($urandom_range(0, 2))
        0:       applyStimulus(1'b0, 1'b0, addr, strb, wd);
        1:       applyStimulus(1'b1, 1'b0, addr, strb, wd);
        default: applyStimulus(1'b1, 1'b1, addr, strb, wd);
      endcase
    end

    tx_ready = 1'b0;
    writeReg(8'h10, 8'h01, 64'h77);
    mmio_req  = 1'b1;
    mmio_we   = 1'b0;
    mmio_addr = BASE + 31'h08;
    #2;
    rst = 1'b1;
    #1;
    mmio_req = 1'b0;
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    rst = 1'b0;
    readReg(8'h08);
    check64("cmp_after_reset", mmio_rdata_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
